// File: rtl/merge_pkg.sv
// Shared definitions for the merger-tree output path: item width,
// end-of-run terminator value and the lane-counter width helper.
package merge_pkg;

   localparam int ITEM_W = 32;
   localparam logic [ITEM_W-1:0] TERMINATOR = 32'hFFFF_FFFF;

   function automatic int lane_cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/merge_out_packer_pack_line_reg.sv
// Output holding register for one packed line with a valid/ready handshake.
// A load always wins over a drain, so back-to-back lines leave no bubble.
module pack_line_reg #(
   parameter int W = 512
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_load_line,
   input  logic         i_load_last,
   input  logic         i_ready,
   output logic [W-1:0] o_line,
   output logic         o_valid,
   output logic         o_last
);

   logic [W-1:0] line_q, line_d;
   logic         valid_q, valid_d;
   logic         last_q, last_d;

   always_comb begin
      line_d  = line_q;
      valid_d = valid_q;
      last_d  = last_q;
      if (i_load) begin
         line_d  = i_load_line;
         valid_d = 1'b1;
         last_d  = i_load_last;
      end else if (valid_q && i_ready) begin
         valid_d = 1'b0;
         last_d  = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         line_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         line_q  <= line_d;
         valid_q <= valid_d;
         last_q  <= last_d;
      end
   end

   assign o_line  = line_q;
   assign o_valid = valid_q;
   assign o_last  = last_q;

endmodule

// File: rtl/merge_out_packer.sv
// Packs the root merger's sorted item stream into N-lane lines, pads and
// flushes the last partial line on the terminator and reports run length.
module merge_out_packer
   import merge_pkg::*;
#(
   parameter int                N          = 16,
   parameter logic [ITEM_W-1:0] TERMINATOR = merge_pkg::TERMINATOR
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [ITEM_W-1:0]     i_data,
   input  logic                  i_write,
   output logic                  o_ready,
   output logic [ITEM_W*N-1:0]   o_line,
   output logic                  o_line_valid,
   output logic                  o_line_last,
   input  logic                  i_line_ready,
   output logic                  o_run_done,
   output logic [31:0]           o_run_len
);

   localparam int CNT_W = lane_cnt_w(N);

   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic [N-1:0][ITEM_W-1:0]    buf_q, buf_d;
   logic [N-1:0][ITEM_W-1:0]    line_build;
   logic [31:0]                 run_cnt_q, run_cnt_d;
   logic [31:0]                 run_len_q, run_len_d;
   logic                        run_done_q, run_done_d;
   logic                        accept;
   logic                        is_term;
   logic                        line_done;

   assign o_ready = ~o_line_valid | i_line_ready;

   always_comb begin
      accept     = i_write & o_ready;
      is_term    = (i_data == TERMINATOR);
      line_done  = accept & (is_term | (cnt_q == CNT_W'(N - 1)));
      line_build = buf_q;
      line_build[cnt_q] = i_data;
      // A terminator closes the line early: every lane above it is padding.
      if (is_term) begin
         for (int k = 0; k < N; k++) begin
            if (k > int'(cnt_q)) line_build[k] = TERMINATOR;
         end
      end

      buf_d      = buf_q;
      cnt_d      = cnt_q;
      run_cnt_d  = run_cnt_q;
      run_len_d  = run_len_q;
      run_done_d = 1'b0;
      if (accept) begin
         buf_d[cnt_q] = i_data;
         if (is_term) begin
            cnt_d      = '0;
            run_cnt_d  = '0;
            run_len_d  = run_cnt_q;
            run_done_d = 1'b1;
         end else begin
            cnt_d     = line_done ? '0 : cnt_q + 1'b1;
            run_cnt_d = run_cnt_q + 32'd1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q      <= '0;
         buf_q      <= '0;
         run_cnt_q  <= '0;
         run_len_q  <= '0;
         run_done_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         buf_q      <= buf_d;
         run_cnt_q  <= run_cnt_d;
         run_len_q  <= run_len_d;
         run_done_q <= run_done_d;
      end
   end

   pack_line_reg #(
      .W (ITEM_W * N)
   ) u_line_reg (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_load      (line_done),
      .i_load_line (line_build),
      .i_load_last (is_term),
      .i_ready     (i_line_ready),
      .o_line      (o_line),
      .o_valid     (o_line_valid),
      .o_last      (o_line_last)
   );

   assign o_run_done = run_done_q;
   assign o_run_len  = run_len_q;

endmodule

// File: tb/tb_merge_out_packer.sv
// Self-checking bench for merge_out_packer (N=4): directed literal checks
// plus randomized traffic compared against a queue-based line model.
module tb_merge_out_packer;
   import merge_pkg::*;

   localparam int N  = 4;
   localparam int LW = 32 * N;
   localparam logic [31:0] TERM = 32'hFFFF_FFFF;

   logic          i_clk = 1'b0;
   logic          i_rst_n = 1'b0;
   logic [31:0]   i_data = '0;
   logic          i_write = 1'b0;
   logic          i_line_ready = 1'b0;
   logic          o_ready;
   logic [LW-1:0] o_line;
   logic          o_line_valid;
   logic          o_line_last;
   logic          o_run_done;
   logic [31:0]   o_run_len;

   merge_out_packer #(.N(N), .TERMINATOR(TERM)) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_data       (i_data),
      .i_write      (i_write),
      .o_ready      (o_ready),
      .o_line       (o_line),
      .o_line_valid (o_line_valid),
      .o_line_last  (o_line_last),
      .i_line_ready (i_line_ready),
      .o_run_done   (o_run_done),
      .o_run_len    (o_run_len)
   );

   always #5 i_clk = ~i_clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic checkOutput(input string nm, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   // Reference model: items of the current run, lines waiting to be taken.
   typedef struct packed {
      logic [LW-1:0] line;
      logic          last;
   } line_t;

   line_t         exp_lines[$];
   logic [31:0]   cur[$];
   logic [31:0]   run_cnt = '0;
   logic [31:0]   len_hold = '0;
   bit            done_pend = 0;
   bit            prev_hold = 0;
   logic [LW-1:0] prev_line = '0;

   function automatic logic [LW-1:0] pack_items();
      logic [LW-1:0] ln;
      ln = '0;
      for (int k = 0; k < N; k++) ln[32*k +: 32] = cur[k];
      return ln;
   endfunction

   always @(negedge i_clk) begin : cmp_blk
      bit ev;
      bit acc;
      line_t ent;
      if (!i_rst_n) begin
         exp_lines.delete();
         cur.delete();
         run_cnt   = '0;
         len_hold  = '0;
         done_pend = 0;
         prev_hold = 0;
      end else begin
         ev = (exp_lines.size() > 0);
         checkOutput("ready", LW'(o_ready), LW'(!ev || i_line_ready));
         checkOutput("line_valid", LW'(o_line_valid), LW'(ev));
         if (ev) begin
            checkOutput("line_data", o_line, exp_lines[0].line);
            checkOutput("line_last", LW'(o_line_last), LW'(exp_lines[0].last));
         end
         if (prev_hold) checkOutput("hold_stable", o_line, prev_line);
         checkOutput("run_done", LW'(o_run_done), LW'(done_pend));
         checkOutput("run_len", LW'(o_run_len), LW'(len_hold));
         checkOutput("write_while_busy", LW'(i_write & ~o_ready), '0);

         prev_hold = o_line_valid && !i_line_ready;
         prev_line = o_line;
         done_pend = 0;
         acc = i_write && (!ev || i_line_ready);
         if (ev && i_line_ready) void'(exp_lines.pop_front());
         if (acc) begin
            if (i_data == TERM) begin
               while (cur.size() < N) cur.push_back(TERM);
               ent.line = pack_items();
               ent.last = 1'b1;
               exp_lines.push_back(ent);
               cur.delete();
               len_hold  = run_cnt;
               run_cnt   = '0;
               done_pend = 1;
            end else begin
               cur.push_back(i_data);
               run_cnt = run_cnt + 32'd1;
               if (cur.size() == N) begin
                  ent.line = pack_items();
                  ent.last = 1'b0;
                  exp_lines.push_back(ent);
                  cur.delete();
               end
            end
         end
      end
   end

   task automatic applyStimulus(input logic wr, input logic [31:0] d, input logic rdy);
      i_line_ready = rdy;
      i_data       = d;
      i_write      = wr;
      @(posedge i_clk);
      #2;
   endtask

   task automatic doReset();
      i_write = 1'b0;
      i_rst_n = 1'b0;
      #1;
      checkOutput("rst_valid", LW'(o_line_valid), '0);
      checkOutput("rst_last", LW'(o_line_last), '0);
      checkOutput("rst_line", o_line, '0);
      checkOutput("rst_done", LW'(o_run_done), '0);
      checkOutput("rst_len", LW'(o_run_len), '0);
      @(posedge i_clk);
      #2;
      i_rst_n = 1'b1;
   endtask

   initial begin
      int items;
      logic [31:0] d;
      logic wr;
      @(posedge i_clk);
      #2;
      doReset();

      // Full line, back-to-back with the sink ready.
      for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 32'(i), 1'b1);
      checkOutput("t1_valid", LW'(o_line_valid), LW'(1));
      checkOutput("t1_line", o_line, 128'h00000004_00000003_00000002_00000001);
      checkOutput("t1_last", LW'(o_line_last), '0);
      applyStimulus(1'b0, '0, 1'b1);

      // Partial line closed by a terminator.
      doReset();
      applyStimulus(1'b1, 32'd5, 1'b1);
      applyStimulus(1'b1, 32'd6, 1'b1);
      applyStimulus(1'b1, TERM, 1'b1);
      checkOutput("t2_line", o_line, 128'hFFFFFFFF_FFFFFFFF_00000006_00000005);
      checkOutput("t2_last", LW'(o_line_last), LW'(1));
      checkOutput("t2_done", LW'(o_run_done), LW'(1));
      checkOutput("t2_len", LW'(o_run_len), LW'(2));
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("t2_done_pulse", LW'(o_run_done), '0);
      checkOutput("t2_len_held", LW'(o_run_len), LW'(2));

      // Empty run, then terminator right on a line boundary.
      doReset();
      applyStimulus(1'b1, TERM, 1'b1);
      checkOutput("t3_line", o_line, {4{TERM}});
      checkOutput("t3_last", LW'(o_line_last), LW'(1));
      checkOutput("t3_len", LW'(o_run_len), '0);
      for (int i = 21; i <= 24; i++) applyStimulus(1'b1, 32'(i), 1'b1);
      checkOutput("t3_full_last", LW'(o_line_last), '0);
      applyStimulus(1'b1, TERM, 1'b1);
      checkOutput("t3b_line", o_line, {4{TERM}});
      checkOutput("t3b_last", LW'(o_line_last), LW'(1));
      checkOutput("t3b_len", LW'(o_run_len), LW'(4));
      applyStimulus(1'b0, '0, 1'b1);

      // Backpressure: the held line blocks further input until drained.
      doReset();
      for (int i = 31; i <= 34; i++) applyStimulus(1'b1, 32'(i), 1'b0);
      applyStimulus(1'b0, '0, 1'b0);
      applyStimulus(1'b0, '0, 1'b0);
      checkOutput("t4_ready_low", LW'(o_ready), '0);
      checkOutput("t4_held", o_line, 128'h00000022_00000021_00000020_0000001F);
      for (int i = 35; i <= 38; i++) applyStimulus(1'b1, 32'(i), 1'b1);
      checkOutput("t4_second", o_line, 128'h00000026_00000025_00000024_00000023);
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("t4_drained", LW'(o_line_valid), '0);

      // Reset while a line is held, and again mid-line.
      doReset();
      for (int i = 41; i <= 44; i++) applyStimulus(1'b1, 32'(i), 1'b0);
      doReset();
      applyStimulus(1'b1, 32'd45, 1'b1);
      applyStimulus(1'b1, 32'd46, 1'b1);
      doReset();
      for (int i = 51; i <= 54; i++) applyStimulus(1'b1, 32'(i), 1'b1);
      checkOutput("t5_line", o_line, 128'h00000036_00000035_00000034_00000033);
      applyStimulus(1'b0, '0, 1'b1);

      // Randomized traffic with random sink stalls and terminators.
      doReset();
      items = 0;
      for (int cyc = 0; cyc < 20000 && items < 10000; cyc++) begin
         i_line_ready = ($urandom_range(0, 9) < 7);
         #1;
         wr = o_ready && ($urandom_range(0, 9) < 8);
         if ($urandom_range(0, 11) == 0) d = TERM;
         else begin
            d = $urandom;
            if (d == TERM) d = 32'd0;
         end
         i_data  = d;
         i_write = wr;
         if (wr) items++;
         @(posedge i_clk);
         #2;
      end
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1);
      checkOutput("final_idle", LW'(o_line_valid), '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
